tuart_tx: RTL and testbench
===========================

// Module: tuart_tx
// PURPOSE
// - Tiny-UART transmitter; the return path from the LogIP core to the host.
// - Accepts one WIDTH-bit word per valid/ready handshake.
// - Serialises the word as WIDTH/DATA_BITS back-to-back UART frames, least significant byte first.
// - Each frame: 1 start bit, DATA_BITS data bits (LSB first), NR_STOP_BITS stop bits; line idles high.
// PARAMETERS
// - WIDTH         32  word width from core; must be a non-zero multiple of DATA_BITS
// - DATA_BITS      8  data bits per frame
// - NR_STOP_BITS   1  stop bits per frame (1 or 2)
// - CLKS_PER_BIT  16  clk_i cycles per bit period (>= 2); internal baud counter
// PORTS
// - clk_i   in   1      system clock, all logic on rising edge
// - rst_in  in   1      asynchronous active-low reset
// - data_i  in   WIDTH  word to transmit; sampled only on accept
// - stb_i   in   1      core request; word accepted when stb_i && rdy_o
// - rdy_o   out  1      high while idle and able to accept a word
// - tx_o    out  1      serial line to host
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE, tx_o=1, rdy_o=1; all counters and shift register 0.
// - Reset mid-frame aborts the transfer: tx_o=1 immediately, no partial frame resumes.
// - Derived: NR_BYTES=WIDTH/DATA_BITS; FRAME=1+DATA_BITS+NR_STOP_BITS bits.
// - tx_o and rdy_o are registered outputs.
// - Accept: in IDLE with stb_i=1, latch data_i into shift register, clear counters.
//   - Next cycle: rdy_o=0 and tx_o=0 (start bit of byte 0).
// - stb_i while rdy_o=0 is ignored; data_i changes after accept have no effect.
// - FSM states IDLE, START, DATA, STOP; baud counter counts 0..CLKS_PER_BIT-1 in every non-IDLE state.
//   - Bit boundary = baud counter wrap; each bit is held exactly CLKS_PER_BIT cycles.
//   - START: tx_o=0; at boundary -> DATA, bit_cnt=0.
//   - DATA: tx_o=shift[bit_cnt] of current byte (LSB first).
//     - At boundary: bit_cnt++; after bit DATA_BITS-1 -> STOP.
//   - STOP: tx_o=1 for NR_STOP_BITS bit periods; at final boundary:
//     - byte_cnt<NR_BYTES-1: byte_cnt++, select next byte -> START (no idle gap between bytes of a word).
//     - byte_cnt==NR_BYTES-1 -> IDLE, rdy_o=1 next cycle.
// - Busy time per word = NR_BYTES*FRAME*CLKS_PER_BIT cycles, measured from the cycle after accept to rdy_o=1.
// - Back-to-back words: stb_i held high is accepted on the first rdy_o=1 cycle.
//   - Exactly one idle-high clk between the last stop bit and the next start bit.
// - Byte select uses byte_cnt*DATA_BITS indexing or right shift by DATA_BITS.
//   - byte_cnt width = $clog2(NR_BYTES) (min 1); bit_cnt width = $clog2(DATA_BITS).
//   - Baud counter width = $clog2(CLKS_PER_BIT); no counter overflows in legal configuration.
// - WIDTH==DATA_BITS degenerates to single-frame transmit; behaviour otherwise identical.
// TESTING (WIDTH=32, DATA_BITS=8, NR_STOP_BITS=1, CLKS_PER_BIT=4 unless noted)
// 1. Reset -> tx_o=1, rdy_o=1; hold 20 cycles with stb_i=0 -> tx_o stays 1, no transitions.
// 2. Word send: stb_i pulse, data_i=32'hA53C0F81.
//    - Bench UART model decodes bytes 81,0F,3C,A5 in order.
//    - Every bit 4 cycles wide; rdy_o low exactly 160 cycles.
// 3. Busy protection: stb_i with 32'hFFFFFFFF during transfer of case 2
//    - Ignored, decoded bytes unchanged, no extra frame.
// 4. Back-to-back: stb_i held high with 32'h00000000 then 32'hFFFFFFFF.
//    - 8 frames decoded; exactly 1 idle-high cycle between words, none between bytes.
// 5. Reset mid-operation: assert rst_in during data bit 3 of byte 1.
//    - tx_o=1, rdy_o=1 asynchronously.
//    - New word 32'h12345678 after release decodes 78,56,34,12 cleanly.
// 6. Config sweep NR_STOP_BITS=2, CLKS_PER_BIT=7, WIDTH=8, data 8'h55.
//    - Stop period 14 cycles high; rdy_o low 77 cycles.

Source files
------------

// File: rtl/tuart_tx.sv
// tuart_tx: UART transmitter that sends a WIDTH-bit word as WIDTH/DATA_BITS frames, least significant byte first.
module tuart_tx #(
  parameter int WIDTH        = 32,
  parameter int DATA_BITS    = 8,
  parameter int NR_STOP_BITS = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] data_i,
  input  logic             stb_i,
  output logic             rdy_o,
  output logic             tx_o
);
  localparam int NR_BYTES = WIDTH / DATA_BITS;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  localparam int YW = NR_BYTES > 1 ? $clog2(NR_BYTES) : 1;
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_MAX  = BW'(DATA_BITS - 1);
  localparam logic [YW-1:0] BYTE_MAX = YW'(NR_BYTES - 1);
  localparam logic          STOP_MAX = 1'(NR_STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [YW-1:0]        byte_q, byte_d;
  logic                 stop_q, stop_d;
  logic [WIDTH-1:0]     shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 rdy_q, rdy_d;
  logic                 wrap;
  logic [DATA_BITS-1:0] cur_byte;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    wrap    = baud_q == BAUD_MAX;
    baud_d  = state_q == IDLE ? baud_q : wrap ? '0 : baud_q + 1'b1;
    case (state_q)
      IDLE: if (stb_i) begin
        state_d = START;
        shift_d = data_i;
        baud_d  = '0;
        bit_d   = '0;
        byte_d  = '0;
        stop_d  = 1'b0;
      end
      START: if (wrap) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (wrap) begin
        bit_d   = bit_q == BIT_MAX ? '0 : bit_q + 1'b1;
        state_d = bit_q == BIT_MAX ? STOP : DATA;
        stop_d  = 1'b0;
      end
      default: if (wrap) begin
        stop_d = stop_q + 1'b1;
        if (stop_q == STOP_MAX) begin
          // Next byte starts immediately; only the end of the word returns to IDLE.
          state_d = byte_q == BYTE_MAX ? IDLE : START;
          byte_d  = byte_q == BYTE_MAX ? byte_q : byte_q + 1'b1;
          shift_d = byte_q == BYTE_MAX ? shift_q : shift_q >> DATA_BITS;
          stop_d  = 1'b0;
        end
      end
    endcase
    cur_byte = shift_d[DATA_BITS-1:0];
    tx_d     = state_d == START ? 1'b0 : state_d == DATA ? cur_byte[bit_d] : 1'b1;
    rdy_d    = state_d == IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      rdy_q   <= rdy_d;
    end
  end

  assign tx_o  = tx_q;
  assign rdy_o = rdy_q;
endmodule

// File: tb/tb_tuart_tx.sv
// tb_tuart_tx: checks tuart_tx line waveforms against an ideal UART waveform model and a mid-bit frame decoder.
module tb_tuart_tx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] data = '0;
  logic        tx0, rdy0, tx6, rdy6, tx_m, rdy_m;
  logic        cap = 1'b0;
  bit          txq[$], rdyq[$], expq[$];
  int          nvec = 0, nmis = 0;

  always #5 clk = ~clk;

  tuart_tx #(.WIDTH(32), .DATA_BITS(8), .NR_STOP_BITS(1), .CLKS_PER_BIT(4)) dut (
    .clk_i(clk), .rst_in(rst_n), .data_i(data), .stb_i(stb & ~sel), .rdy_o(rdy0), .tx_o(tx0));
  tuart_tx #(.WIDTH(8), .DATA_BITS(8), .NR_STOP_BITS(2), .CLKS_PER_BIT(7)) dut6 (
    .clk_i(clk), .rst_in(rst_n), .data_i(data[7:0]), .stb_i(stb & sel), .rdy_o(rdy6), .tx_o(tx6));

  assign tx_m  = sel ? tx6 : tx0;
  assign rdy_m = sel ? rdy6 : rdy0;

  always @(negedge clk) if (cap) begin
    txq.push_back(tx_m);
    rdyq.push_back(rdy_m);
  end

  typedef struct {
    logic [31:0] d;
    int          poke;
    bit          b2b;
    logic [31:0] d2;
    bit          sel;
    int          busy;
    logic [63:0] word;
    int          frames;
  } vec_t;

  function automatic int cpb();
    return sel ? 7 : 4;
  endfunction
  function automatic int nbytes();
    return sel ? 1 : 4;
  endfunction
  function automatic int nstop();
    return sel ? 2 : 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ideal line waveform of one word, one entry per clock.
  task automatic model(input logic [31:0] d);
    for (int b = 0; b < nbytes(); b++) begin
      repeat (cpb()) expq.push_back(1'b0);
      for (int k = 0; k < 8; k++) repeat (cpb()) expq.push_back(d[8*b+k]);
      repeat (nstop() * cpb()) expq.push_back(1'b1);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!rdy_m && n < 1000) begin
      tick();
      n++;
    end
    if (!rdy_m) check("ready_timeout", 64'(rdy_m), 64'd1);
  endtask

  task automatic run(input vec_t v);
    int          flen, fr, i, busy, bad, first, st;
    logic [7:0]  byt;
    logic [63:0] w;
    sel = v.sel;
    wait_ready();
    txq.delete();
    rdyq.delete();
    expq.delete();
    model(v.d);
    if (v.b2b) begin
      expq.push_back(1'b1);
      model(v.d2);
    end
    stb  = 1'b1;
    data = v.d;
    tick();
    cap  = 1'b1;
    st   = v.b2b ? 1 : 0;
    if (!v.b2b) stb = 1'b0;
    if (!v.b2b) data = $urandom;
    for (int c = 0; c < expq.size() + 12; c++) begin
      if (v.poke != 0 && c == v.poke) begin
        stb  = 1'b1;
        data = 32'hFFFFFFFF;
      end else if (v.poke != 0 && c == v.poke + 1) stb = 1'b0;
      if (st == 1 && c > 0 && rdy_m) begin
        data = v.d2;
        st   = 2;
      end
      tick();
      if (st == 2) begin
        stb  = 1'b0;
        data = $urandom;
        st   = 3;
      end
    end
    cap = 1'b0;
    while (expq.size() < txq.size()) expq.push_back(1'b1);
    bad   = 0;
    first = -1;
    for (int c = 0; c < txq.size(); c++) if (txq[c] != expq[c]) begin
      bad++;
      if (first < 0) first = c;
    end
    check("waveform_mismatch_count", 64'(bad), 64'd0);
    if (bad != 0) $display("  first differing cycle %0d", first);
    busy = 0;
    while (busy < rdyq.size() && !rdyq[busy]) busy++;
    check("rdy_low_cycles", 64'(busy), 64'(v.busy));
    flen = (1 + 8 + nstop()) * cpb();
    fr = 0;
    w  = '0;
    i  = 0;
    while (i + flen <= txq.size()) begin
      if (!txq[i]) begin
        for (int k = 0; k < 8; k++) byt[k] = txq[i + (1 + k) * cpb() + cpb() / 2];
        if (fr < 8) w |= 64'(byt) << (8 * fr);
        fr++;
        i += flen;
      end else i++;
    end
    check("frames_decoded", 64'(fr), 64'(v.frames));
    check("decoded_bytes", w, v.word);
  endtask

  vec_t vt[4];

  initial begin
    int   trans;
    vec_t r;
    vt[0] = '{32'hA53C0F81, 0,  1'b0, 32'h0,        1'b0, 160, 64'hA53C0F81,          4};
    vt[1] = '{32'hA53C0F81, 50, 1'b0, 32'h0,        1'b0, 160, 64'hA53C0F81,          4};
    vt[2] = '{32'h00000000, 0,  1'b1, 32'hFFFFFFFF, 1'b0, 160, 64'hFFFFFFFF_00000000, 8};
    vt[3] = '{32'h00000055, 0,  1'b0, 32'h0,        1'b1, 77,  64'h55,                1};

    tick();
    check("reset_tx", 64'(tx0), 64'd1);
    check("reset_rdy", 64'(rdy0), 64'd1);
    rst_n = 1'b1;
    tick();
    trans = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (tx0 !== 1'b1 || rdy0 !== 1'b1) trans++;
    end
    check("idle_line_disturbed", 64'(trans), 64'd0);

    foreach (vt[k]) run(vt[k]);
    sel = 1'b0;

    // Reset during data bit 3 of byte 1 (cycles 56..59 after accept).
    wait_ready();
    stb  = 1'b1;
    data = 32'h0;
    tick();
    stb = 1'b0;
    repeat (57) tick();
    check("pre_reset_tx_low", 64'(tx0), 64'd0);
    check("pre_reset_busy", 64'(rdy0), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_tx", 64'(tx0), 64'd1);
    check("async_reset_rdy", 64'(rdy0), 64'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    r = '{32'h12345678, 0, 1'b0, 32'h0, 1'b0, 160, 64'h12345678, 4};
    run(r);

    for (int n = 0; n < 8; n++) begin
      r.d      = $urandom;
      r.poke   = (n % 2) ? int'($urandom_range(1, 150)) : 0;
      r.b2b    = 1'b0;
      r.d2     = '0;
      r.sel    = 1'b0;
      r.busy   = 4 * (1 + 8 + 1) * 4;
      r.word   = 64'(r.d);
      r.frames = 4;
      run(r);
    end
    for (int n = 0; n < 3; n++) begin
      r.d      = 32'($urandom_range(0, 255));
      r.poke   = 30;
      r.sel    = 1'b1;
      r.busy   = (1 + 8 + 2) * 7;
      r.word   = 64'(r.d);
      r.frames = 1;
      run(r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
